i2s_tx_stereo: RTL and testbench
================================

# i2s_tx_stereo

Parametrised stereo I2S/left-justified transmitter that replaces the fixed 16-bit sine-shifting output path feeding the audio DAC Pmod. It generates MCLK, SCK and LRCK from the system clock with programmable ratios. It accepts stereo sample pairs through a valid/ready handshake with a one-pair holding buffer. It serialises MSB-first with zero padding to the slot width and flags underruns when no sample is available at a frame boundary.

## Interface
Parameters:
- SAMPLE_W, 16: bits per channel sample; 8..32, must be ≤ SLOT_W.
- SLOT_W, 32: SCK periods per channel slot; frame = 2*SLOT_W SCK periods.
- MCLK_HALF, 2: clk cycles per MCLK half-period; ≥1.
- SCK_HALF, 8: clk cycles per SCK half-period; ≥1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- enable  in  1  1 = run SCK/LRCK/serial path; 0 = idle.
- mode_lj  in  1  0 = I2S (one-bit delay, LRCK low = left); 1 = left-justified (LRCK high = left).
- s_valid  in  1  sample pair valid.
- s_ready  out  1  holding buffer empty.
- s_left  in  SAMPLE_W  left sample, two's complement.
- s_right  in  SAMPLE_W  right sample.
- mclk  out  1  master clock to DAC.
- sck  out  1  serial bit clock.
- lrck  out  1  word select.
- sdout  out  1  serial data.
- frame_start  out  1  one-clk pulse at each frame load.
- underrun  out  1  one-clk pulse when a frame loads with an empty holding buffer.

One clock; reset is asynchronous and active-low.

## Operation
- Reset (rst=0): mclk=0, sck=0, lrck=0, sdout=0, s_ready=1, frame_start=0, underrun=0; holding buffer empty; all counters 0. Takes effect immediately, including mid-frame.
- MCLK: free-running counter; mclk toggles every MCLK_HALF clk cycles whenever rst=1, independent of enable.
- Handshake: transfer when s_valid & s_ready. The pair is captured into the holding buffer and s_ready drops on the next clk. s_ready rises on the clk after the buffer is emptied by a frame load. Data is ignored while s_ready=0. The handshake operates regardless of enable.
- SCK: while enable=1, the counter toggles sck every SCK_HALF cycles, starting low. A falling edge (1→0) starts a bit period and advances the bit index k = 0..2*SLOT_W-1, wrapping after 2*SLOT_W-1.
- Frame load at the falling edge starting k=0:
  - mode_lj is sampled at this point and held for the whole frame.
  - If the buffer is full: shift reg ← {s_left, zeros(SLOT_W-SAMPLE_W), s_right, zeros(SLOT_W-SAMPLE_W)}, buffer emptied.
  - Else: shift reg ← 0 and underrun pulses.
  - frame_start pulses in both cases.
- sdout in bit period k = shift-reg bit [2*SLOT_W-1-k]. sdout changes only at SCK falling edges.
- lrck:
  - LJ: lrck=1 for k in [0, SLOT_W-1], 0 otherwise.
  - I2S: lrck=1 for k in [SLOT_W-1, 2*SLOT_W-2], 0 otherwise. This places the MSB one SCK after the LRCK edge.
- enable 1→0: on the next clk, sck=0, lrck=0, sdout=0, SCK counter and k cleared. The holding buffer is kept.
- enable 0→1: sck rises after SCK_HALF cycles. The first falling edge (2*SCK_HALF cycles after enable) is k=0 and frame-loads.
- A handshake on the same clk as a frame load with the buffer empty is not transmitted this frame. underrun fires and the new pair goes out next frame.

## Timing
- SCK period = 2*SCK_HALF clk; frame = 4*SLOT_W*SCK_HALF clk (1024 at defaults).
- Default ratios: MCLK = clk/4, SCK = clk/16, MCLK/LRCK = 256, SCK/LRCK = 64.
- sck, lrck, sdout, frame_start and underrun update on the same clk edge as the SCK falling transition; all are registered outputs.
- Sample latency: accepted pair reaches sdout MSB at the next frame load, at most one frame + 1 clk.
- Sustained throughput: one pair per frame. s_ready is high from 1 clk after the frame load until acceptance.

## Test plan
- Reset, defaults, mode_lj=1, enable=1, push L=16'hA5C3, R=16'h0F0F before the first frame:
  - frame_start at clk 16 after enable.
  - sdout bits 0..15 = A5C3 MSB-first, 16..31 = 0, 32..47 = 0F0F, 48..63 = 0.
  - lrck high for the first 32 SCKs.
- Same data with mode_lj=0:
  - lrck rises at the falling edge of k=31 and falls at k=63.
  - Data bits are identical to the LJ case.
- No sample pushed:
  - underrun pulses once per frame.
  - sdout stays 0.
  - s_ready stays 1.
- Back-to-back: source always valid:
  - exactly one transfer per 1024 clk.
  - no underrun after the first frame.
  - s_ready is low for 1023 of every 1024 cycles.
- Assert rst=0 mid-frame at k=20: all outputs go to reset values without waiting for clk. After release, MCLK restarts at 0 and the buffer is empty.
- SAMPLE_W=24, SLOT_W=24, SCK_HALF=2, MCLK_HALF=1:
  - frame = 192 clk.
  - L=24'h800001 appears as 1, 22 zeros, 1.
  - mclk toggles every clk.

Source files
------------

// File: rtl/i2s_tx_stereo.sv
// Stereo I2S / left-justified transmitter with programmable MCLK/SCK ratios and a one-pair holding buffer.
// Frame load at the SCK falling edge that starts bit 0; an empty buffer at that point sends silence and pulses underrun.
module i2s_tx_stereo #(
    parameter int SAMPLE_W  = 16,
    parameter int SLOT_W    = 32,
    parameter int MCLK_HALF = 2,
    parameter int SCK_HALF  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                mode_lj,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_left,
    input  logic [SAMPLE_W-1:0] s_right,
    output logic                mclk,
    output logic                sck,
    output logic                lrck,
    output logic                sdout,
    output logic                frame_start,
    output logic                underrun
);

    localparam int FRAME_W = 2 * SLOT_W;
    localparam int KW      = $clog2(FRAME_W);
    localparam int MCW     = $clog2(MCLK_HALF + 1);
    localparam int SCW     = $clog2(SCK_HALF + 1);

    localparam logic [MCW-1:0] MC_LAST  = MCW'(MCLK_HALF - 1);
    localparam logic [SCW-1:0] SC_LAST  = SCW'(SCK_HALF - 1);
    localparam logic [KW-1:0]  K_LAST   = KW'(FRAME_W - 1);
    localparam logic [KW-1:0]  K_SLOT   = KW'(SLOT_W);
    localparam logic [KW-1:0]  K_I2S_LO = KW'(SLOT_W - 1);
    localparam logic [KW-1:0]  K_I2S_HI = KW'(FRAME_W - 2);

    logic [MCW-1:0]      mcnt_q, mcnt_d;
    logic                mclk_q, mclk_d;
    logic [SCW-1:0]      scnt_q, scnt_d;
    logic                sck_q, sck_d;
    logic [KW-1:0]       k_q, k_d;
    logic                lrck_q, lrck_d;
    logic                sdout_q, sdout_d;
    logic [FRAME_W-1:0]  sh_q, sh_d;
    logic                mode_q, mode_d;
    logic                fs_q, fs_d;
    logic                ur_q, ur_d;
    logic                full_q, full_d;
    logic [SAMPLE_W-1:0] bl_q, bl_d;
    logic [SAMPLE_W-1:0] br_q, br_d;

    logic                load;
    logic                mode_cur;
    logic [SLOT_W-1:0]   slot_l;
    logic [SLOT_W-1:0]   slot_r;
    logic [FRAME_W-1:0]  frame;

    always_comb begin
        mcnt_d = mcnt_q + 1'b1;
        mclk_d = mclk_q;
        if (mcnt_q == MC_LAST) begin
            mcnt_d = '0;
            mclk_d = ~mclk_q;
        end

        scnt_d   = scnt_q;
        sck_d    = sck_q;
        k_d      = k_q;
        lrck_d   = lrck_q;
        sdout_d  = sdout_q;
        sh_d     = sh_q;
        mode_d   = mode_q;
        fs_d     = 1'b0;
        ur_d     = 1'b0;
        load     = 1'b0;
        mode_cur = mode_q;
        slot_l   = '0;
        slot_r   = '0;
        slot_l[SLOT_W-1 -: SAMPLE_W] = bl_q;
        slot_r[SLOT_W-1 -: SAMPLE_W] = br_q;
        frame    = full_q ? {slot_l, slot_r} : '0;

        if (!enable) begin
            scnt_d  = '0;
            sck_d   = 1'b0;
            k_d     = '0;
            lrck_d  = 1'b0;
            sdout_d = 1'b0;
        end else if (scnt_q != SC_LAST) begin
            scnt_d = scnt_q + 1'b1;
        end else begin
            scnt_d = '0;
            sck_d  = ~sck_q;
            // k_q is the index of the bit period this falling edge starts
            if (sck_q) begin
                load = (k_q == '0);
                if (load) begin
                    mode_cur = mode_lj;
                    mode_d   = mode_lj;
                    fs_d     = 1'b1;
                    ur_d     = ~full_q;
                    sdout_d  = frame[FRAME_W-1];
                    sh_d     = {frame[FRAME_W-2:0], 1'b0};
                end else begin
                    sdout_d  = sh_q[FRAME_W-1];
                    sh_d     = {sh_q[FRAME_W-2:0], 1'b0};
                end
                lrck_d = mode_cur ? (k_q < K_SLOT)
                                  : ((k_q >= K_I2S_LO) && (k_q <= K_I2S_HI));
                k_d    = (k_q == K_LAST) ? '0 : k_q + 1'b1;
            end
        end

        full_d = full_q;
        bl_d   = bl_q;
        br_d   = br_q;
        if (s_valid && !full_q) begin
            full_d = 1'b1;
            bl_d   = s_left;
            br_d   = s_right;
        end else if (load && full_q) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcnt_q  <= '0;
            mclk_q  <= 1'b0;
            scnt_q  <= '0;
            sck_q   <= 1'b0;
            k_q     <= '0;
            lrck_q  <= 1'b0;
            sdout_q <= 1'b0;
            sh_q    <= '0;
            mode_q  <= 1'b0;
            fs_q    <= 1'b0;
            ur_q    <= 1'b0;
            full_q  <= 1'b0;
            bl_q    <= '0;
            br_q    <= '0;
        end else begin
            mcnt_q  <= mcnt_d;
            mclk_q  <= mclk_d;
            scnt_q  <= scnt_d;
            sck_q   <= sck_d;
            k_q     <= k_d;
            lrck_q  <= lrck_d;
            sdout_q <= sdout_d;
            sh_q    <= sh_d;
            mode_q  <= mode_d;
            fs_q    <= fs_d;
            ur_q    <= ur_d;
            full_q  <= full_d;
            bl_q    <= bl_d;
            br_q    <= br_d;
        end
    end

    assign s_ready     = ~full_q;
    assign mclk        = mclk_q;
    assign sck         = sck_q;
    assign lrck        = lrck_q;
    assign sdout       = sdout_q;
    assign frame_start = fs_q;
    assign underrun    = ur_q;

endmodule

// File: tb/tb_i2s_tx_stereo.sv
// Directed bench: default-parameter instance (16-bit samples, 32-bit slots) and a 24/24 fast-clock instance.
module tb_i2s_tx_stereo;

    logic        clk = 1'b0;
    logic        rst, enable, mode_lj, s_valid;
    logic        s_ready;
    logic [15:0] s_left, s_right;
    logic        mclk, sck, lrck, sdout, frame_start, underrun;

    logic        rst2, en2, valid2;
    logic        ready2;
    logic [23:0] left2, right2;
    logic        mclk2, sck2, lrck2, sdout2, fs2, ur2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    i2s_tx_stereo u_dut (
        .clk(clk), .rst(rst), .enable(enable), .mode_lj(mode_lj),
        .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_right(s_right),
        .mclk(mclk), .sck(sck), .lrck(lrck), .sdout(sdout),
        .frame_start(frame_start), .underrun(underrun)
    );

    i2s_tx_stereo #(.SAMPLE_W(24), .SLOT_W(24), .MCLK_HALF(1), .SCK_HALF(2)) u_w24 (
        .clk(clk), .rst(rst2), .enable(en2), .mode_lj(mode_lj),
        .s_valid(valid2), .s_ready(ready2), .s_left(left2), .s_right(right2),
        .mclk(mclk2), .sck(sck2), .lrck(lrck2), .sdout(sdout2),
        .frame_start(fs2), .underrun(ur2)
    );

    task automatic wait_fs1(output int n, output bit ok);
        n = 0;
        ok = 1'b0;
        while (!ok && n < 3000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (frame_start) ok = 1'b1;
        end
    endtask

    task automatic wait_fs2(output int n, output bit ok);
        n = 0;
        ok = 1'b0;
        while (!ok && n < 1000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (fs2) ok = 1'b1;
        end
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        @(negedge clk);
        s_valid = 1'b1;
        s_left  = l;
        s_right = r;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic collect64(output logic [63:0] d, output logic [63:0] l);
        for (int i = 0; i < 64; i++) begin
            d[63-i] = sdout;
            l[63-i] = lrck;
            if (i < 63) repeat (16) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        #1;
        vectors++;
        if ({mclk, sck, lrck, sdout, s_ready, frame_start, underrun} !== 7'b0000100) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b want 0000100",
                     {mclk, sck, lrck, sdout, s_ready, frame_start, underrun});
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_lj;
        int n; bit ok;
        logic [63:0] d, l;
        mode_lj = 1'b1;
        push(16'hA5C3, 16'h0F0F);
        vectors++;
        if (s_ready !== 1'b0) begin
            miscompares++; $display("FAIL lj_ready_drop: got %b want 0", s_ready);
        end
        enable = 1'b1;
        wait_fs1(n, ok);
        vectors++;
        if (!ok || n != 16) begin
            miscompares++; $display("FAIL lj_first_frame: got %0d clk (seen %0d) want 16", n, ok);
        end
        vectors++;
        if ({underrun, s_ready} !== 2'b01) begin
            miscompares++; $display("FAIL lj_load_flags: got %b want 01", {underrun, s_ready});
        end
        collect64(d, l);
        vectors++;
        if (d !== 64'hA5C3_0000_0F0F_0000) begin
            miscompares++; $display("FAIL lj_data: got %h want a5c300000f0f0000", d);
        end
        vectors++;
        if (l !== 64'hFFFF_FFFF_0000_0000) begin
            miscompares++; $display("FAIL lj_lrck: got %h want ffffffff00000000", l);
        end
        repeat (16) @(negedge clk);
        vectors++;
        if ({frame_start, underrun} !== 2'b11) begin
            miscompares++; $display("FAIL lj_next_underrun: got %b want 11", {frame_start, underrun});
        end
    endtask

    task automatic test_i2s;
        int n; bit ok;
        logic [63:0] d, l;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({sck, lrck, sdout} !== 3'b000) begin
            miscompares++; $display("FAIL disable_idle: got %b want 000", {sck, lrck, sdout});
        end
        mode_lj = 1'b0;
        push(16'hA5C3, 16'h0F0F);
        enable = 1'b1;
        wait_fs1(n, ok);
        vectors++;
        if (!ok || n != 16) begin
            miscompares++; $display("FAIL i2s_first_frame: got %0d clk (seen %0d) want 16", n, ok);
        end
        collect64(d, l);
        vectors++;
        if (d !== 64'hA5C3_0000_0F0F_0000) begin
            miscompares++; $display("FAIL i2s_data: got %h want a5c300000f0f0000", d);
        end
        vectors++;
        if (l !== 64'h0000_0001_FFFF_FFFE) begin
            miscompares++; $display("FAIL i2s_lrck: got %h want 00000001fffffffe", l);
        end
    endtask

    task automatic test_underrun;
        int ur_cnt = 0, fs_cnt = 0, nrdy = 0, sd_hi = 0;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        enable = 1'b1;
        for (int i = 0; i < 2070; i++) begin
            @(negedge clk);
            ur_cnt += int'(underrun);
            fs_cnt += int'(frame_start);
            nrdy   += int'(!s_ready);
            sd_hi  += int'(sdout);
        end
        vectors++;
        if (ur_cnt != 3 || fs_cnt != 3) begin
            miscompares++; $display("FAIL underrun_count: got ur=%0d fs=%0d want 3/3", ur_cnt, fs_cnt);
        end
        vectors++;
        if (nrdy != 0 || sd_hi != 0) begin
            miscompares++; $display("FAIL underrun_idle: got not_ready=%0d sdout_hi=%0d want 0/0", nrdy, sd_hi);
        end
    endtask

    task automatic test_back_to_back;
        int n; bit ok;
        int rdy_hi = 0, ur_cnt = 0, fs_cnt = 0;
        enable = 1'b0;
        @(negedge clk);
        mode_lj = 1'b1;
        s_valid = 1'b1;
        s_left  = 16'h1234;
        s_right = 16'h5678;
        enable  = 1'b1;
        wait_fs1(n, ok);
        vectors++;
        if (!ok || n != 16 || underrun !== 1'b0) begin
            miscompares++; $display("FAIL b2b_first: got %0d clk ur=%b want 16 clk ur=0", n, underrun);
        end
        for (int i = 0; i < 3072; i++) begin
            rdy_hi += int'(s_ready);
            ur_cnt += int'(underrun);
            fs_cnt += int'(frame_start);
            @(negedge clk);
        end
        s_valid = 1'b0;
        vectors++;
        if (rdy_hi != 3 || fs_cnt != 3 || ur_cnt != 0) begin
            miscompares++;
            $display("FAIL b2b_rate: got ready_hi=%0d fs=%0d ur=%0d want 3/3/0", rdy_hi, fs_cnt, ur_cnt);
        end
    endtask

    task automatic test_async_reset;
        int n; bit ok;
        logic [3:0] mc;
        wait_fs1(n, ok);
        push(16'hFFFF, 16'hFFFF);
        repeat (20 * 16 + 12 - 2) @(negedge clk);
        vectors++;
        if ({s_ready, lrck, sck} !== 3'b011 || !ok) begin
            miscompares++; $display("FAIL pre_reset: got %b want 011", {s_ready, lrck, sck});
        end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({mclk, sck, lrck, sdout, s_ready, frame_start, underrun} !== 7'b0000100) begin
            miscompares++;
            $display("FAIL async_reset: got %b want 0000100",
                     {mclk, sck, lrck, sdout, s_ready, frame_start, underrun});
        end
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mc[3-i] = mclk;
        end
        vectors++;
        if (mc !== 4'b0110 || s_ready !== 1'b1) begin
            miscompares++; $display("FAIL mclk_restart: got %b rdy=%b want 0110 rdy=1", mc, s_ready);
        end
    endtask

    task automatic test_w24;
        int n; bit ok;
        logic [7:0]  mc;
        logic [47:0] d, l;
        @(negedge clk);
        rst2 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            mc[7-i] = mclk2;
        end
        vectors++;
        if (mc !== 8'b1010_1010) begin
            miscompares++; $display("FAIL w24_mclk: got %b want 10101010", mc);
        end
        mode_lj = 1'b1;
        valid2  = 1'b1;
        left2   = 24'h800001;
        right2  = 24'h123456;
        @(posedge clk);
        @(negedge clk);
        valid2 = 1'b0;
        en2    = 1'b1;
        wait_fs2(n, ok);
        vectors++;
        if (!ok || n != 4 || ur2 !== 1'b0) begin
            miscompares++; $display("FAIL w24_first: got %0d clk ur=%b want 4 clk ur=0", n, ur2);
        end
        for (int i = 0; i < 48; i++) begin
            d[47-i] = sdout2;
            l[47-i] = lrck2;
            if (i < 47) repeat (4) @(negedge clk);
        end
        vectors++;
        if (d !== 48'h800001_123456) begin
            miscompares++; $display("FAIL w24_data: got %h want 800001123456", d);
        end
        vectors++;
        if (l !== 48'hFFFFFF_000000) begin
            miscompares++; $display("FAIL w24_lrck: got %h want ffffff000000", l);
        end
        wait_fs2(n, ok);
        wait_fs2(n, ok);
        vectors++;
        if (!ok || n != 192 || ur2 !== 1'b1) begin
            miscompares++; $display("FAIL w24_frame_len: got %0d clk ur=%b want 192 clk ur=1", n, ur2);
        end
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; mode_lj = 1'b1; s_valid = 1'b0;
        s_left = '0; s_right = '0;
        rst2 = 1'b0; en2 = 1'b0; valid2 = 1'b0; left2 = '0; right2 = '0;
        test_reset;
        test_lj;
        test_i2s;
        test_underrun;
        test_back_to_back;
        test_async_reset;
        test_w24;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
